mode_display_mux: RTL and testbench
===================================

# mode_display_mux

Parametrised mode arbiter and multiplexed seven-segment driver for the clock front end. It selects one of NUM_MODES display sources (clock, count-up, count-down, timer, alarm, …) from level-held mode switches with fixed priority, and manages each mode's sticky start flag. It decodes the selected source's BCD digits and scans them onto a DIGITS-wide common-anode display, with optional per-mode blinking. It replaces hard-wired per-mode muxing at the top level.

## Interface
- NUM_MODES, 4: number of selectable modes; index 0 has highest priority.
- DIGITS, 4: number of display digits.
- SCAN_DIV, 100000: clk cycles per digit slot.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- AUTO_START, 4'b0011: bit i=1 means mode i starts as soon as it is selected; bit i=0 means mode i waits for run_req[i].
- CLEAR_ON_LEAVE, 0: 1 means start[i] clears when mode i is deselected; 0 means flags clear only in idle (no mode requested).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- mode_req  in  NUM_MODES  level mode switches.
- run_req  in  NUM_MODES  start request, honoured only for the active mode.
- blink_req  in  NUM_MODES  blink display while that mode is active.
- bcd_in  in  NUM_MODES*DIGITS*4  mode i, digit d nibble at [(i*DIGITS+d)*4 +: 4]; digit 0 is rightmost.
- home_bcd  in  DIGITS*4  digits shown in idle.
- active  out  NUM_MODES  registered one-hot selected mode; all zero in idle.
- start  out  NUM_MODES  sticky per-mode start flags.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- AN  out  DIGITS  active-low digit enables.

## Operation
- Selection: active is loaded every cycle with the one-hot of the lowest set index in mode_req, or zero if mode_req is zero.
- Start flags, evaluated every cycle against the registered active:
  - Set: start[i] sets when active[i]=1 and (AUTO_START[i] or run_req[i]).
  - Hold: a set flag holds while no clear condition applies.
  - Idle clear: all flags clear when mode_req is zero.
  - Leave clear: if CLEAR_ON_LEAVE=1, start[i] also clears on the cycle active[i] becomes 0.
  - Priority: clear wins over set in the same cycle.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At its terminal count the digit index advances, wrapping from DIGITS-1 to 0.
  - AN drives the current digit low and all others high.
- Decode: the nibble of the current digit comes from the active mode's bcd_in, or from home_bcd in idle.
  - 0-9 map to standard active-low patterns: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - 10-15 produce blank (7'h7F).
- Blink:
  - The phase toggles every BLINK_DIV cycles.
  - When blink_req of the active mode is 1 and the phase is off, AN is all ones and seg is 7'h7F.
  - blink_req is ignored in idle.
- Mode change: any change of active resets the prescaler, the digit index and the blink phase (to on) in the same cycle.
- Reset: while reset is low at a clk edge, the following values load:
  - active=0, start=0, prescaler=0, digit=0, blink phase on.
  - AN all ones, seg=7'h7F.
  - Reset mid-operation discards all flags and the scan position.

## Timing
- Latency from mode_req to active: 1 cycle.
- Latency from active to start (auto-start mode): 1 cycle.
- Latency from active to new-source seg/AN: 1 cycle. seg and AN are registered from active, digit and phase.
- run_req is sampled every cycle. A single-cycle pulse while mode i is active sets start[i] on the next edge.
- Each digit is lit for exactly SCAN_DIV cycles; a full frame is DIGITS*SCAN_DIV cycles.
- Simultaneous requests: the lowest index wins; higher indices are ignored until the lower one drops.
- After reset release, the first digit-0 slot lasts SCAN_DIV cycles and begins with the first registered output.

## Test plan
All scenarios use NUM_MODES=4, DIGITS=4, SCAN_DIV=4, BLINK_DIV=16.
- Reset: hold reset low for 3 cycles with random inputs -> AN=4'b1111, seg=7'h7F, start=0, active=0. After release, AN=4'b1110 for 4 cycles, then 4'b1101, and so on, wrapping after 4'b0111.
- Auto-start and priority: mode_req=4'b0011 -> active=4'b0001 after 1 cycle, start=4'b0001 after 2 cycles. Drop bit 0 -> active=4'b0010, start=4'b0011 (CLEAR_ON_LEAVE=0). mode_req=0 -> start=0.
- Gated start: mode_req=4'b0100; pulse run_req[1] -> no effect. Pulse run_req[2] for 1 cycle -> start[2]=1 and it stays 1 until mode_req=0.
- CLEAR_ON_LEAVE=1: start[0] set; switch to mode 1 -> start[0] clears on the cycle active[0] falls.
- Decode: mode 3 bcd=16'h1A80 -> digits 0..3 show 7'b1000000, 7'b0000000, 7'h7F, 7'b1111001. Idle shows home_bcd.
- Blink and mode-change restart: blink_req[1]=1 on active mode 1 -> AN alternates 16 cycles scanning, 16 cycles all ones. A mode switch mid-frame restarts at AN=4'b1110 with the phase on.

Source files
------------

// File: rtl/mode_display_mux.sv
// mode_display_mux
//   Fixed-priority mode arbiter with sticky per-mode start flags, feeding a
//   time-multiplexed common-anode seven-segment scanner with per-mode blink.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   mode_req   [NUM_MODES]          level mode switches, index 0 highest priority
//   run_req    [NUM_MODES]          start request, honoured only for the active mode
//   blink_req  [NUM_MODES]          blink the display while that mode is active
//   bcd_in     [NUM_MODES*DIGITS*4] mode i digit d at [(i*DIGITS+d)*4 +: 4], digit 0 rightmost
//   home_bcd   [DIGITS*4]           digits shown when no mode is requested
//   active     [NUM_MODES]          registered one-hot selected mode, zero in idle
//   start      [NUM_MODES]          sticky per-mode start flags
//   seg        [7]                  active-low segments, seg[0]=a .. seg[6]=g
//   AN         [DIGITS]             active-low digit enables
module mode_display_mux #(
    parameter int                   NUM_MODES      = 4,
    parameter int                   DIGITS         = 4,
    parameter int                   SCAN_DIV       = 100000,
    parameter int                   BLINK_DIV      = 25000000,
    parameter logic [NUM_MODES-1:0] AUTO_START     = NUM_MODES'(4'b0011),
    parameter bit                   CLEAR_ON_LEAVE = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MODES-1:0]          mode_req,
    input  logic [NUM_MODES-1:0]          run_req,
    input  logic [NUM_MODES-1:0]          blink_req,
    input  logic [NUM_MODES*DIGITS*4-1:0] bcd_in,
    input  logic [DIGITS*4-1:0]           home_bcd,
    output logic [NUM_MODES-1:0]          active,
    output logic [NUM_MODES-1:0]          start,
    output logic [6:0]                    seg,
    output logic [DIGITS-1:0]             AN
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DIG_W   = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(DIGITS - 1);

    logic [NUM_MODES-1:0] active_nxt;
    logic [NUM_MODES-1:0] start_nxt;
    logic                 idle;
    logic                 mode_chg;

    logic [SCAN_W-1:0]    presc;
    logic [DIG_W-1:0]     digit;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 phase_on;

    logic [3:0]           nib;
    logic [6:0]           seg_dec;
    logic [DIGITS-1:0]    an_dec;
    logic                 blank;

    // ------------------------------------------------------------------
    // Arbitration: isolate the lowest set request bit (x & -x).
    // ------------------------------------------------------------------
    assign idle       = ~|mode_req;
    assign active_nxt = mode_req & (~mode_req + NUM_MODES'(1));
    // The scan position and blink phase restart on the same edge that
    // loads a different selection, so the new source opens on digit 0.
    assign mode_chg   = (active_nxt != active);

    // ------------------------------------------------------------------
    // Sticky start flags; any clear condition overrides a set.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_MODES; i++) begin : g_start
        logic set_i, leave_i;
        assign set_i   = active[i] & (AUTO_START[i] | run_req[i]);
        assign leave_i = CLEAR_ON_LEAVE & active[i] & ~active_nxt[i];
        assign start_nxt[i] = (idle | leave_i) ? 1'b0 : (start[i] | set_i);
    end

    // ------------------------------------------------------------------
    // Digit source: active mode's nibble, or home digits in idle.
    // ------------------------------------------------------------------
    always_comb begin
        nib = 4'h0;
        for (int d = 0; d < DIGITS; d++) begin
            if (digit == DIG_W'(d)) begin
                if (idle_sel()) nib = home_bcd[d*4 +: 4];
                for (int m = 0; m < NUM_MODES; m++)
                    if (active[m]) nib = bcd_in[(m*DIGITS + d)*4 +: 4];
            end
        end
    end

    function automatic logic idle_sel();
        return ~|active;
    endfunction

    function automatic logic [6:0] seg_pat(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    assign seg_dec = seg_pat(nib);
    assign an_dec  = ~(DIGITS'(1) << digit);
    // In idle active is zero, so blink_req drops out naturally.
    assign blank   = (|(blink_req & active)) & ~phase_on;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            active    <= '0;
            start     <= '0;
            presc     <= '0;
            digit     <= '0;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            seg       <= 7'h7F;
            AN        <= '1;
        end else begin
            active <= active_nxt;
            start  <= start_nxt;

            if (blank) begin
                seg <= 7'h7F;
                AN  <= '1;
            end else begin
                seg <= seg_dec;
                AN  <= an_dec;
            end

            if (mode_chg) begin
                presc     <= '0;
                digit     <= '0;
                blink_cnt <= '0;
                phase_on  <= 1'b1;
            end else begin
                if (presc == SCAN_LAST) begin
                    presc <= '0;
                    digit <= (digit == DIG_LAST) ? '0 : digit + DIG_W'(1);
                end else begin
                    presc <= presc + SCAN_W'(1);
                end

                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase_on  <= ~phase_on;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mode_display_mux.sv
module tb_mode_display_mux;

    localparam int NM = 4;
    localparam int DG = 4;
    localparam int SD = 4;
    localparam int BD = 16;
    localparam logic [3:0] AUTO = 4'b0011;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NM-1:0]  mode_req = '0, run_req = '0, blink_req = '0;
    logic [63:0]    bcd_in = '0;
    logic [15:0]    home_bcd = '0;

    logic [3:0] active0, start0, an0, active1, start1, an1;
    logic [6:0] seg0, seg1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mode_display_mux #(.NUM_MODES(NM), .DIGITS(DG), .SCAN_DIV(SD), .BLINK_DIV(BD),
                       .AUTO_START(AUTO), .CLEAR_ON_LEAVE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .mode_req(mode_req), .run_req(run_req),
        .blink_req(blink_req), .bcd_in(bcd_in), .home_bcd(home_bcd),
        .active(active0), .start(start0), .seg(seg0), .AN(an0));

    mode_display_mux #(.NUM_MODES(NM), .DIGITS(DG), .SCAN_DIV(SD), .BLINK_DIV(BD),
                       .AUTO_START(AUTO), .CLEAR_ON_LEAVE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .mode_req(mode_req), .run_req(run_req),
        .blink_req(blink_req), .bcd_in(bcd_in), .home_bcd(home_bcd),
        .active(active1), .start(start1), .seg(seg1), .AN(an1));

    // ---------------- reference model ----------------
    // m_t counts edges since the last epoch (reset or a selection change);
    // digit and blink phase follow from it by plain division.
    logic [3:0] m_act = '0, m_st0 = '0, m_st1 = '0, m_an = '1;
    logic [6:0] m_seg = 7'h7F;
    int         m_t = 0;

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (n < 10) ? tbl[n] : 7'h7F;
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] r);
        for (int i = 0; i < NM; i++) if (r[i]) return 4'(1 << i);
        return 4'b0;
    endfunction

    task automatic tick();
        logic [3:0] na, nib;
        int d, idx;
        bit on, set;
        if (!reset) begin
            m_act = '0; m_st0 = '0; m_st1 = '0; m_t = 0; m_an = '1; m_seg = 7'h7F;
        end else begin
            na  = lowest(mode_req);
            d   = (m_t / SD) % DG;
            on  = ((m_t / BD) % 2) == 0;
            idx = -1;
            for (int i = 0; i < NM; i++) if (m_act[i]) idx = i;
            nib = (idx < 0) ? home_bcd[d*4 +: 4] : bcd_in[(idx*DG + d)*4 +: 4];
            if (idx >= 0 && blink_req[idx] && !on) begin
                m_an = 4'hF; m_seg = 7'h7F;
            end else begin
                m_an = ~(4'b1 << d); m_seg = pat(nib);
            end
            for (int i = 0; i < NM; i++) begin
                set = m_act[i] && (AUTO[i] || run_req[i]);
                m_st0[i] = (mode_req == 0) ? 1'b0 : (m_st0[i] | set);
                m_st1[i] = (mode_req == 0 || (m_act[i] && !na[i])) ? 1'b0 : (m_st1[i] | set);
            end
            m_t   = (na != m_act) ? 0 : m_t + 1;
            m_act = na;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            mode_req = 4'($urandom); run_req = 4'($urandom); blink_req = 4'($urandom);
            bcd_in = {$urandom, $urandom}; home_bcd = 16'($urandom);
            tick();
            total++;
            if ({an0, seg0, start0, active0, start1, active1} !== {4'hF, 7'h7F, 4'h0, 4'h0, 4'h0, 4'h0}) begin
                bad++;
                $display("FAIL reset_state an=%b seg=%h st=%b act=%b st1=%b act1=%b want an=1111 seg=7f st=0 act=0",
                         an0, seg0, start0, active0, start1, active1);
            end
        end
        reset = 1; mode_req = '0; run_req = '0; blink_req = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (an0 !== ~(4'b1 << ((k / 4) % 4)) || {an0, seg0} !== {m_an, m_seg}) begin
                bad++;
                $display("FAIL reset_scan k=%0d an=%b seg=%h want an=%b seg=%h",
                         k, an0, seg0, ~(4'b1 << ((k / 4) % 4)), m_seg);
            end
        end
    endtask

    task automatic test_autostart_priority();
        mode_req = 4'b0011;
        tick();
        total++;
        if (active0 !== 4'b0001) begin bad++; $display("FAIL prio_active act=%b want 0001", active0); end
        tick();
        total++;
        if (start0 !== 4'b0001 || start1 !== 4'b0001) begin
            bad++; $display("FAIL auto_start st0=%b st1=%b want 0001", start0, start1);
        end
        tick();
        mode_req = 4'b0010;
        tick();
        total++;
        if (active0 !== 4'b0010 || start0 !== 4'b0001 || start1 !== 4'b0000) begin
            bad++; $display("FAIL drop_bit0 act=%b st0=%b st1=%b want 0010 0001 0000", active0, start0, start1);
        end
        tick();
        total++;
        if (start0 !== 4'b0011 || start1 !== 4'b0010) begin
            bad++; $display("FAIL hold_start st0=%b st1=%b want 0011 0010", start0, start1);
        end
        mode_req = 4'b0000;
        tick();
        total++;
        if (start0 !== 4'b0000 || start1 !== 4'b0000 || active0 !== 4'b0000) begin
            bad++; $display("FAIL idle_clear st0=%b st1=%b act=%b want 0", start0, start1, active0);
        end
    endtask

    task automatic test_gated_start();
        mode_req = 4'b0100;
        tick(); tick();
        run_req = 4'b0010; tick(); run_req = '0; tick();
        total++;
        if (start0 !== 4'b0000) begin bad++; $display("FAIL gated_other st=%b want 0000", start0); end
        run_req = 4'b0100; tick(); run_req = '0;
        total++;
        if (start0 !== 4'b0100) begin bad++; $display("FAIL run_pulse st=%b want 0100", start0); end
        for (int k = 0; k < 6; k++) begin
            run_req = 4'($urandom) & 4'b1011;
            tick();
            total++;
            if (start0 !== 4'b0100 || start1 !== m_st1) begin
                bad++; $display("FAIL run_hold k=%0d st=%b want 0100", k, start0);
            end
        end
        run_req = '0; mode_req = '0;
        tick();
        total++;
        if (start0 !== 4'b0000) begin bad++; $display("FAIL gated_idle st=%b want 0000", start0); end
    endtask

    task automatic test_clear_on_leave();
        mode_req = 4'b0001;
        tick(); tick();
        total++;
        if (start1 !== 4'b0001) begin bad++; $display("FAIL col_set st1=%b want 0001", start1); end
        mode_req = 4'b0010;
        tick();
        total++;
        if (active1 !== 4'b0010 || start1[0] !== 1'b0 || start0[0] !== 1'b1) begin
            bad++; $display("FAIL col_leave act1=%b st1=%b st0=%b want 0010 xxx0 xxx1", active1, start1, start0);
        end
        mode_req = '0; tick();
    endtask

    task automatic test_decode();
        logic [6:0] exp_dec [4] = '{7'b1000000, 7'b0000000, 7'h7F, 7'b1111001};
        bcd_in = {16'h1A80, 16'($urandom), 16'($urandom), 16'($urandom)};
        blink_req = '0;
        mode_req = 4'b1000;
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (seg0 !== exp_dec[k / 4] || an0 !== ~(4'b1 << (k / 4))) begin
                bad++; $display("FAIL decode k=%0d seg=%b an=%b want seg=%b an=%b",
                                k, seg0, an0, exp_dec[k / 4], ~(4'b1 << (k / 4)));
            end
        end
        home_bcd = 16'($urandom);
        mode_req = '0;
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (seg0 !== pat(home_bcd[(k / 4)*4 +: 4]) || {an0, seg0} !== {m_an, m_seg}) begin
                bad++; $display("FAIL decode_home k=%0d seg=%b an=%b want seg=%b an=%b",
                                k, seg0, an0, m_seg, m_an);
            end
        end
    endtask

    task automatic test_blink_restart();
        logic [3:0] exp_an;
        bcd_in = {$urandom, $urandom};
        blink_req = 4'b0010; mode_req = 4'b0010;
        tick();
        for (int k = 0; k < 85; k++) begin
            tick();
            exp_an = (((k / 16) % 2) == 0) ? ~(4'b1 << ((k / 4) % 4)) : 4'hF;
            total++;
            if (an0 !== exp_an || {an0, seg0} !== {m_an, m_seg}) begin
                bad++; $display("FAIL blink k=%0d an=%b seg=%h want an=%b seg=%h", k, an0, seg0, exp_an, m_seg);
            end
        end
        // switch while phase is off and mid-frame
        blink_req = 4'b0011; mode_req = 4'b0001;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_an = (k < 16) ? ~(4'b1 << (k / 4)) : 4'hF;
            total++;
            if (an0 !== exp_an) begin
                bad++; $display("FAIL restart k=%0d an=%b want %b", k, an0, exp_an);
            end
        end
        blink_req = '0; mode_req = '0; tick();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 40);
                mode_req  = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
                blink_req = 4'($urandom);
                if ($urandom_range(0, 3) == 0) bcd_in = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) home_bcd = 16'($urandom);
            end
            hold--;
            run_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            reset   = ($urandom_range(0, 199) != 0);
            tick();
            total++;
            if ({active0, start0, an0, seg0} !== {m_act, m_st0, m_an, m_seg} ||
                {active1, start1, an1, seg1} !== {m_act, m_st1, m_an, m_seg}) begin
                bad++;
                $display("FAIL random k=%0d act=%b st0=%b st1=%b an=%b seg=%h want act=%b st0=%b st1=%b an=%b seg=%h",
                         k, active0, start0, start1, an0, seg0, m_act, m_st0, m_st1, m_an, m_seg);
            end
        end
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_autostart_priority();
        test_gated_start();
        test_clear_on_leave();
        test_decode();
        test_blink_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
